// File: rtl/mem_pkg.sv
// Shared memory-access definitions: request size encodings
// and the size-to-byte-count helper used by memory initiators.
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   // Size code 3 is treated as a word.
   function automatic logic [2:0] size_bytes(input logic [1:0] sz);
      logic [2:0] n;
      case (sz)
         SZ_BYTE: n = 3'd1;
         SZ_HALF: n = 3'd2;
         default: n = 3'd4;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/ram_ctrl.sv
// Byte-wide RAM initiator: splits 1/2/4-byte CPU requests into
// byte transactions and assembles little-endian read words.
module ram_ctrl
   import mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 17
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic                  req_valid_in,
   output logic                  req_ready_out,
   input  logic                  req_we_in,
   input  logic [1:0]            req_size_in,
   input  logic [ADDR_WIDTH-1:0] req_addr_in,
   input  logic [31:0]           req_wdata_in,
   output logic                  resp_valid_out,
   output logic [31:0]           resp_rdata_out,
   output logic                  ram_en_out,
   output logic                  ram_r_nw_out,
   output logic [ADDR_WIDTH-1:0] ram_a_out,
   output logic [7:0]            ram_d_out,
   input  logic [7:0]            ram_d_in
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, WRITE} state_e;

   state_e                state_q, state_d;
   logic [1:0]            cnt_q, cnt_d;
   logic [1:0]            last_q, last_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [31:0]           shift_q, shift_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  resp_q, resp_d;
   logic                  en_q, en_d;
   logic                  rnw_q, rnw_d;
   logic [ADDR_WIDTH-1:0] a_q, a_d;
   logic [7:0]            d_q, d_d;
   logic [2:0]            nbytes;
   logic [31:0]           shifted;
   logic [31:0]           wsh;

   // Next-state, byte sequencing and read assembly.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      wdata_d = wdata_q;
      shift_d = shift_q;
      rdata_d = rdata_q;
      resp_d  = 1'b0;
      en_d    = en_q;
      rnw_d   = rnw_q;
      a_d     = a_q;
      d_d     = d_q;
      nbytes  = size_bytes(req_size_in);
      shifted = {ram_d_in, shift_q[31:8]};
      wsh     = wdata_q >> {cnt_q + 2'd1, 3'b000};
      unique case (state_q)
         IDLE: begin
            en_d  = 1'b0;
            rnw_d = 1'b1;
            if (req_valid_in) begin
               last_d  = 2'(nbytes - 3'd1);
               cnt_d   = 2'd0;
               wdata_d = req_wdata_in;
               shift_d = 32'h0;
               a_d     = req_addr_in;
               en_d    = 1'b1;
               rnw_d   = ~req_we_in;
               if (req_we_in) begin
                  d_d     = req_wdata_in[7:0];
                  state_d = WRITE;
               end else begin
                  state_d = READ;
               end
            end
         end
         READ: begin
            if (cnt_q != 2'd0) shift_d = shifted;
            if (cnt_q == last_q) begin
               state_d = DRAIN;
            end else begin
               a_d   = a_q + ADDR_WIDTH'(1);
               cnt_d = cnt_q + 2'd1;
            end
         end
         DRAIN: begin
            state_d = IDLE;
            en_d    = 1'b0;
            resp_d  = 1'b1;
            rdata_d = shifted >> {2'd3 - last_q, 3'b000};
         end
         WRITE: begin
            if (cnt_q == last_q) begin
               state_d = IDLE;
               en_d    = 1'b0;
               rnw_d   = 1'b1;
               resp_d  = 1'b1;
            end else begin
               a_d   = a_q + ADDR_WIDTH'(1);
               cnt_d = cnt_q + 2'd1;
               d_d   = wsh[7:0];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered RAM-port outputs.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         last_q  <= 2'd0;
         wdata_q <= 32'h0;
         shift_q <= 32'h0;
         rdata_q <= 32'h0;
         resp_q  <= 1'b0;
         en_q    <= 1'b0;
         rnw_q   <= 1'b1;
         a_q     <= '0;
         d_q     <= 8'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         wdata_q <= wdata_d;
         shift_q <= shift_d;
         rdata_q <= rdata_d;
         resp_q  <= resp_d;
         en_q    <= en_d;
         rnw_q   <= rnw_d;
         a_q     <= a_d;
         d_q     <= d_d;
      end
   end

   assign req_ready_out  = (state_q == IDLE);
   assign resp_valid_out = resp_q;
   assign resp_rdata_out = rdata_q;
   assign ram_en_out     = en_q;
   assign ram_r_nw_out   = rnw_q;
   assign ram_a_out      = a_q;
   assign ram_d_out      = d_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: behavioural RAM, byte-array reference
// model, vector table, corner sequences and random traffic.
module tb_ram_ctrl;

   localparam int AW    = 17;
   localparam int MEMSZ = 1 << AW;

   logic          clk;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [1:0]    req_size;
   logic [AW-1:0] req_addr;
   logic [31:0]   req_wdata;
   logic          resp_valid;
   logic [31:0]   resp_rdata;
   logic          ram_en;
   logic          ram_r_nw;
   logic [AW-1:0] ram_a;
   logic [7:0]    ram_d_o;
   logic [7:0]    ram_d_i;

   logic [7:0]    ram_mem [0:MEMSZ-1];
   logic [7:0]    ref_mem [0:MEMSZ-1];
   logic [7:0]    ram_q;

   int            n_chk  = 0;
   int            n_fail = 0;
   logic [31:0]   last_rd = 32'h0;

   ram_ctrl #(.ADDR_WIDTH(AW)) dut (
      .clk_in         (clk),
      .rst_n_in       (rst_n),
      .req_valid_in   (req_valid),
      .req_ready_out  (req_ready),
      .req_we_in      (req_we),
      .req_size_in    (req_size),
      .req_addr_in    (req_addr),
      .req_wdata_in   (req_wdata),
      .resp_valid_out (resp_valid),
      .resp_rdata_out (resp_rdata),
      .ram_en_out     (ram_en),
      .ram_r_nw_out   (ram_r_nw),
      .ram_a_out      (ram_a),
      .ram_d_out      (ram_d_o),
      .ram_d_in       (ram_d_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read RAM; read data gated by en.
   initial begin
      ram_q = 8'h00;
      for (int i = 0; i < MEMSZ; i++) ram_mem[i] = 8'($urandom);
      forever begin
         @(posedge clk);
         if (ram_en) begin
            if (ram_r_nw) ram_q <= ram_mem[ram_a];
            else ram_mem[ram_a] <= ram_d_o;
         end
      end
   end
   assign ram_d_i = ram_en ? ram_q : 8'h00;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic int nb(input logic [1:0] sz);
      return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic [31:0] model_read(input logic [AW-1:0] ad,
                                              input logic [1:0] sz);
      logic [31:0]   r;
      logic [AW-1:0] p;
      r = 32'h0;
      for (int i = 0; i < nb(sz); i++) begin
         p = ad + AW'(i);
         r[8*i +: 8] = ref_mem[p];
      end
      return r;
   endfunction

   task automatic drive(input bit we, input logic [1:0] sz,
                        input logic [AW-1:0] ad, input logic [31:0] wd);
      req_valid = 1'b1;
      req_we    = we;
      req_size  = sz;
      req_addr  = ad;
      req_wdata = wd;
   endtask

   // Follows one accepted transaction cycle by cycle up to its response.
   task automatic run_txn(input bit we, input logic [1:0] sz,
                          input logic [AW-1:0] ad, input logic [31:0] wd,
                          input bit hold, output logic [31:0] rd,
                          output int lat);
      int            n;
      int            act;
      int            idx;
      bit            ok;
      logic [AW-1:0] ea;
      n   = nb(sz);
      act = we ? n : n + 1;
      ok  = 1'b1;
      lat = 0;
      rd  = 32'h0;
      for (int c = 1; c <= 12; c++) begin
         if (c == 1 && !hold) req_valid = 1'b0;
         if (resp_valid) begin
            lat = c;
            rd  = resp_rdata;
            if (ram_en !== 1'b0 || ram_r_nw !== 1'b1 || req_ready !== 1'b1)
               ok = 1'b0;
            break;
         end
         if (c <= act) begin
            idx = (c - 1 < n - 1) ? c - 1 : n - 1;
            ea  = ad + AW'(idx);
            if (ram_en !== 1'b1 || ram_r_nw !== !we || ram_a !== ea ||
                req_ready !== 1'b0)
               ok = 1'b0;
            if (we && ram_d_o !== wd[8*idx +: 8]) ok = 1'b0;
         end else if (ram_en !== 1'b0) begin
            ok = 1'b0;
         end
         @(posedge clk);
         #1;
      end
      chk(we ? "write_seq" : "read_seq", 32'(ok), 32'd1);
      chk(we ? "write_latency" : "read_latency", 32'(lat),
          32'(we ? n + 1 : n + 2));
   endtask

   // Applies the reference-model effect of a completed transaction.
   task automatic score(input bit we, input logic [1:0] sz,
                        input logic [AW-1:0] ad, input logic [31:0] wd,
                        input logic [31:0] rd);
      logic [AW-1:0] p;
      bit            ok;
      if (we) begin
         for (int i = 0; i < nb(sz); i++) begin
            p = ad + AW'(i);
            ref_mem[p] = wd[8*i +: 8];
         end
         ok = 1'b1;
         for (int i = -1; i <= nb(sz); i++) begin
            p = ad + AW'(i);
            if (ram_mem[p] !== ref_mem[p]) ok = 1'b0;
         end
         chk("ram_bytes", 32'(ok), 32'd1);
         chk("write_rdata_hold", rd, last_rd);
      end else begin
         chk("read_data", rd, model_read(ad, sz));
         last_rd = model_read(ad, sz);
      end
   endtask

   task automatic do_op(input bit we, input logic [1:0] sz,
                        input logic [AW-1:0] ad, input logic [31:0] wd,
                        output logic [31:0] rd);
      int lat;
      drive(we, sz, ad, wd);
      @(posedge clk);
      #1;
      run_txn(we, sz, ad, wd, 1'b0, rd, lat);
      score(we, sz, ad, wd, rd);
   endtask

   task automatic chk_reset_outs(input string nm);
      chk({nm, "_en"}, 32'(ram_en), 32'd0);
      chk({nm, "_rnw"}, 32'(ram_r_nw), 32'd1);
      chk({nm, "_a"}, 32'(ram_a), 32'd0);
      chk({nm, "_d"}, 32'(ram_d_o), 32'd0);
      chk({nm, "_resp"}, 32'(resp_valid), 32'd0);
      chk({nm, "_rdata"}, resp_rdata, 32'd0);
      chk({nm, "_ready"}, 32'(req_ready), 32'd1);
   endtask

   typedef struct {
      bit            we;
      logic [1:0]    sz;
      logic [AW-1:0] ad;
      logic [31:0]   wd;
      logic [31:0]   exp;
   } vec_t;

   vec_t        vecs [9];
   logic [31:0] rd;
   int          lat;
   int          pulses;

   initial begin
      vecs[0] = '{1'b1, 2'd2, 17'h00010, 32'hDEADBEEF, 32'h0};
      vecs[1] = '{1'b0, 2'd2, 17'h00010, 32'h0, 32'hDEADBEEF};
      vecs[2] = '{1'b0, 2'd0, 17'h00012, 32'h0, 32'h000000AD};
      vecs[3] = '{1'b1, 2'd1, 17'h00011, 32'h00001234, 32'h0};
      vecs[4] = '{1'b0, 2'd2, 17'h00010, 32'h0, 32'hDE1234EF};
      vecs[5] = '{1'b1, 2'd2, 17'h1FFFE, 32'hA1B2C3D4, 32'h0};
      vecs[6] = '{1'b0, 2'd2, 17'h1FFFE, 32'h0, 32'hA1B2C3D4};
      vecs[7] = '{1'b0, 2'd1, 17'h1FFFF, 32'h0, 32'h0000B2C3};
      vecs[8] = '{1'b0, 2'd3, 17'h00010, 32'h0, 32'hDE1234EF};

      rst_n     = 1'b0;
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_size  = 2'd2;
      req_addr  = 17'h00100;
      req_wdata = 32'h55AA55AA;
      #2;
      for (int i = 0; i < MEMSZ; i++) ref_mem[i] = ram_mem[i];

      // Reset held with a request present: nothing may start.
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outs("in_reset");
      req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_reset_outs("after_reset");

      // Directed vectors.
      foreach (vecs[i]) begin
         do_op(vecs[i].we, vecs[i].sz, vecs[i].ad, vecs[i].wd, rd);
         if (!vecs[i].we) chk("table_rdata", rd, vecs[i].exp);
      end

      // Back-to-back: valid held high across a write and a read.
      drive(1'b1, 2'd2, 17'h00200, 32'h0BADF00D);
      @(posedge clk);
      #1;
      run_txn(1'b1, 2'd2, 17'h00200, 32'h0BADF00D, 1'b1, rd, lat);
      score(1'b1, 2'd2, 17'h00200, 32'h0BADF00D, rd);
      chk("b2b_ready_in_ack", 32'(req_ready), 32'd1);
      drive(1'b0, 2'd2, 17'h00200, 32'h0);
      @(posedge clk);
      #1;
      run_txn(1'b0, 2'd2, 17'h00200, 32'h0, 1'b0, rd, lat);
      score(1'b0, 2'd2, 17'h00200, 32'h0, rd);
      chk("b2b_rdata", rd, 32'h0BADF00D);

      // Reset asserted in cycle 3 of a word read.
      drive(1'b0, 2'd2, 17'h00010, 32'h0);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("mid_read_en_before", 32'(ram_en), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_read_en_drop", 32'(ram_en), 32'd0);
      chk("mid_read_ready", 32'(req_ready), 32'd1);
      pulses = 0;
      for (int c = 0; c < 4; c++) begin
         if (resp_valid) pulses++;
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         if (resp_valid) pulses++;
      end
      chk("mid_read_no_resp", 32'(pulses), 32'd0);
      last_rd = 32'h0;
      do_op(1'b0, 2'd2, 17'h00010, 32'h0, rd);
      chk("after_mid_reset_rdata", rd, 32'hDE1234EF);

      // Random traffic, biased toward the top of the address space.
      for (int i = 0; i < 60; i++) begin
         logic [AW-1:0] ad;
         if ($urandom_range(0, 2) == 0)
            ad = 17'h1FFFC + AW'($urandom_range(0, 5));
         else
            ad = AW'($urandom);
         do_op(1'($urandom), 2'($urandom), ad, $urandom, rd);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
